// File: rtl/gpio_serial_loader_if.sv
// Configuration bus, transfer handshake and serial chain signals of the GPIO serial loader.
// The master side drives writes and start; the slave (loader) drives status and the chain.
interface gpio_serial_loader_if #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = $clog2(NUM_IO);

  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [CFG_BITS-1:0] cfg_wdata;
  logic [CFG_BITS-1:0] cfg_rdata;
  logic                start;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start,
    input  cfg_rdata, busy, done, cfg_err, serial_clock, serial_data, serial_load
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start,
    output cfg_rdata, busy, done, cfg_err, serial_clock, serial_data, serial_load
  );
endinterface

// File: rtl/gpio_serial_loader.sv
// Per-pad GPIO configuration register file that shifts all words MSB-first down the
// padframe control chain and then strobes a common load so every pad latches together.
module gpio_serial_loader #(
  parameter int                  NUM_IO      = 38,
  parameter int                  CFG_BITS    = 13,
  parameter int                  CLK_DIV     = 2,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = CFG_BITS'(13'h0403)
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  gpio_serial_loader_if.slave bus
);

  localparam int AW = $clog2(NUM_IO);
  localparam int BW = $clog2(CFG_BITS);
  localparam int DW = $clog2(CLK_DIV + 1);

  localparam logic [AW-1:0] LAST_WORD = AW'(NUM_IO - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DIV_END   = DW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SHIFT_LO   = 3'd1;
  localparam logic [2:0] SHIFT_HI   = 3'd2;
  localparam logic [2:0] LOAD_SETUP = 3'd3;
  localparam logic [2:0] LOAD       = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  logic [CFG_BITS-1:0] mem_q [NUM_IO];

  logic [2:0]    state_q,   state_d;
  logic [AW-1:0] wordIdx_q, wordIdx_d;
  logic [BW-1:0] bitIdx_q,  bitIdx_d;
  logic [DW-1:0] divCnt_q,  divCnt_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          cfgErr_q,  cfgErr_d;
  logic          serClk_q,  serClk_d;
  logic          serData_q, serData_d;
  logic          serLoad_q, serLoad_d;

  logic          addrOk;
  logic          phaseEnd;
  logic          lastBit;
  logic [AW-1:0] nextWord;
  logic [BW-1:0] nextBit;

  assign addrOk   = (bus.cfg_addr <= LAST_WORD);
  assign phaseEnd = (divCnt_q == DIV_END);
  assign lastBit  = (wordIdx_q == '0) && (bitIdx_q == '0);
  assign nextWord = (bitIdx_q == '0) ? (wordIdx_q - AW'(1)) : wordIdx_q;
  assign nextBit  = (bitIdx_q == '0) ? LAST_BIT : (bitIdx_q - BW'(1));

  // The word/bit pair walks the flattened vector from its top bit down to word[0][0].
  always_comb begin
    state_d   = state_q;
    wordIdx_d = wordIdx_q;
    bitIdx_d  = bitIdx_q;
    divCnt_d  = phaseEnd ? '0 : (divCnt_q + DW'(1));
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfgErr_d  = bus.cfg_we && (busy_q || !addrOk);
    serClk_d  = serClk_q;
    serData_d = serData_q;
    serLoad_d = serLoad_q;
    case (state_q)
      IDLE: begin
        divCnt_d = '0;
        if (bus.start) begin
          state_d   = SHIFT_LO;
          busy_d    = 1'b1;
          wordIdx_d = LAST_WORD;
          bitIdx_d  = LAST_BIT;
          serData_d = mem_q[LAST_WORD][LAST_BIT];
        end
      end
      SHIFT_LO: begin
        if (phaseEnd) begin
          state_d  = SHIFT_HI;
          serClk_d = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phaseEnd) begin
          serClk_d = 1'b0;
          if (lastBit) begin
            state_d   = LOAD_SETUP;
            serData_d = 1'b0;
          end else begin
            state_d   = SHIFT_LO;
            wordIdx_d = nextWord;
            bitIdx_d  = nextBit;
            serData_d = mem_q[nextWord][nextBit];
          end
        end
      end
      LOAD_SETUP: begin
        if (phaseEnd) begin
          state_d   = LOAD;
          serLoad_d = 1'b1;
        end
      end
      LOAD: begin
        if (phaseEnd) begin
          state_d   = DONE;
          serLoad_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        divCnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      wordIdx_q <= '0;
      bitIdx_q  <= '0;
      divCnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfgErr_q  <= 1'b0;
      serClk_q  <= 1'b0;
      serData_q <= 1'b0;
      serLoad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wordIdx_q <= wordIdx_d;
      bitIdx_q  <= bitIdx_d;
      divCnt_q  <= divCnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfgErr_q  <= cfgErr_d;
      serClk_q  <= serClk_d;
      serData_q <= serData_d;
      serLoad_q <= serLoad_d;
    end
  end

  // Writes are locked out for the whole transfer so the shifted image stays coherent.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_IO; i++) begin
        mem_q[i] <= DEFAULT_CFG;
      end
    end else if (bus.cfg_we && !busy_q && addrOk) begin
      mem_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  assign bus.cfg_rdata    = addrOk ? mem_q[bus.cfg_addr] : '0;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = cfgErr_q;
  assign bus.serial_clock = serClk_q;
  assign bus.serial_data  = serData_q;
  assign bus.serial_load  = serLoad_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader: random register contents checked against a
// flat-vector reference model of the shifted stream, plus collision and reset cases.
module tb_gpio_serial_loader;

  localparam int NUM_IO   = 38;
  localparam int CFG_BITS = 13;
  localparam int CLK_DIV  = 2;
  localparam int TOTAL    = NUM_IO * CFG_BITS;
  localparam int BUSY_LEN = TOTAL * 2 * CLK_DIV + 2 * CLK_DIV;
  localparam logic [CFG_BITS-1:0] DEF = 13'h0403;

  logic clock;
  logic reset;

  gpio_serial_loader_if #(.NUM_IO(NUM_IO), .CFG_BITS(CFG_BITS)) ifc ();

  gpio_serial_loader #(
    .NUM_IO     (NUM_IO),
    .CFG_BITS   (CFG_BITS),
    .CLK_DIV    (CLK_DIV),
    .DEFAULT_CFG(DEF)
  ) dut (
    .wb_clk_i(clock),
    .wb_rst_i(reset),
    .bus     (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectorsApplied = 0;
  int miscompares    = 0;

  logic [CFG_BITS-1:0] refMem [NUM_IO];

  logic capBits [$];
  logic prevSclk = 1'b0;
  int   busyCnt  = 0;
  int   loadCnt  = 0;
  int   doneCnt  = 0;
  int   overlap  = 0;

  // Chain observer on the falling edge: records data at each serial_clock rise.
  always @(negedge clock) begin
    if (ifc.serial_clock && !prevSclk) capBits.push_back(ifc.serial_data);
    prevSclk <= ifc.serial_clock;
    if (ifc.busy)        busyCnt <= busyCnt + 1;
    if (ifc.serial_load) loadCnt <= loadCnt + 1;
    if (ifc.done)        doneCnt <= doneCnt + 1;
    if (ifc.serial_load && ifc.serial_clock) overlap <= overlap + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input int addr, input logic [CFG_BITS-1:0] wdata,
                               input logic st);
    ifc.cfg_we    = we;
    ifc.cfg_addr  = 6'(addr);
    ifc.cfg_wdata = wdata;
    ifc.start     = st;
    @(posedge clock);
    #1;
    ifc.cfg_we = 1'b0;
    ifc.start  = 1'b0;
  endtask

  task automatic waitDone(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < BUSY_LEN + 500; c++) begin
      @(posedge clock);
      #1;
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Expected stream is the flattened {word[N-1],...,word[0]} read from its top bit down.
  function automatic int streamErrors(input int base);
    int errs = 0;
    for (int i = 0; i < TOTAL; i++) begin
      int f = TOTAL - 1 - i;
      logic [CFG_BITS-1:0] w = refMem[f / CFG_BITS];
      if (base + i >= capBits.size()) errs++;
      else if (capBits[base + i] !== w[f % CFG_BITS]) errs++;
    end
    return errs;
  endfunction

  task automatic runTransfer(input string tag, input bit collide);
    int   base  = capBits.size();
    int   busy0 = busyCnt;
    int   load0 = loadCnt;
    int   done0 = doneCnt;
    int   ovl0  = overlap;
    int   a;
    logic seen;
    applyStimulus(1'b0, 0, '0, 1'b1);
    checkOutput({tag, "_busy_rise"}, 32'(ifc.busy), 32'd1);
    if (collide) begin
      repeat (100) @(posedge clock);
      #1;
      a = $urandom_range(0, NUM_IO - 1);
      applyStimulus(1'b1, a, ~refMem[a], 1'b0);
      checkOutput({tag, "_err_busy_write"}, 32'(ifc.cfg_err), 32'd1);
      checkOutput({tag, "_word_kept"}, 32'(ifc.cfg_rdata), 32'(refMem[a]));
      repeat (100) @(posedge clock);
      #1;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput({tag, "_start_ignored_err"}, 32'(ifc.cfg_err), 32'd0);
    end
    waitDone(seen);
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(ifc.busy), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    checkOutput({tag, "_rises"}, 32'(capBits.size() - base), 32'(TOTAL));
    checkOutput({tag, "_stream_errs"}, 32'(streamErrors(base)), 32'd0);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt - busy0), 32'(BUSY_LEN));
    checkOutput({tag, "_load_cycles"}, 32'(loadCnt - load0), 32'(CLK_DIV));
    checkOutput({tag, "_done_pulses"}, 32'(doneCnt - done0), 32'd1);
    checkOutput({tag, "_clk_load_overlap"}, 32'(overlap - ovl0), 32'd0);
  endtask

  initial begin
    int             a;
    logic [CFG_BITS-1:0] d;
    logic           seen;

    reset         = 1'b1;
    ifc.cfg_we    = 1'b0;
    ifc.cfg_addr  = '0;
    ifc.cfg_wdata = '0;
    ifc.start     = 1'b0;
    for (int i = 0; i < NUM_IO; i++) refMem[i] = DEF;

    #1;
    checkOutput("rst_busy",  32'(ifc.busy),         32'd0);
    checkOutput("rst_done",  32'(ifc.done),         32'd0);
    checkOutput("rst_err",   32'(ifc.cfg_err),      32'd0);
    checkOutput("rst_sclk",  32'(ifc.serial_clock), 32'd0);
    checkOutput("rst_sdata", 32'(ifc.serial_data),  32'd0);
    checkOutput("rst_sload", 32'(ifc.serial_load),  32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NUM_IO; i++) begin
      ifc.cfg_addr = 6'(i);
      #1;
      checkOutput("rdata_after_reset", 32'(ifc.cfg_rdata), 32'(DEF));
    end

    for (int k = 0; k < 60; k++) begin
      a = (k == 0) ? 0 : (k == 1) ? NUM_IO - 1 : $urandom_range(0, NUM_IO - 1);
      d = CFG_BITS'($urandom);
      applyStimulus(1'b1, a, d, 1'b0);
      refMem[a] = d;
      checkOutput("write_err", 32'(ifc.cfg_err), 32'd0);
      checkOutput("write_readback", 32'(ifc.cfg_rdata), 32'(d));
    end

    applyStimulus(1'b1, NUM_IO, CFG_BITS'($urandom), 1'b0);
    checkOutput("oor_err_pulse", 32'(ifc.cfg_err), 32'd1);
    checkOutput("oor_rdata", 32'(ifc.cfg_rdata), 32'd0);
    applyStimulus(1'b1, 63, CFG_BITS'($urandom), 1'b0);
    checkOutput("oor63_err_pulse", 32'(ifc.cfg_err), 32'd1);
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("oor_err_clears", 32'(ifc.cfg_err), 32'd0);
    for (int i = 0; i < NUM_IO; i++) begin
      ifc.cfg_addr = 6'(i);
      #1;
      checkOutput("oor_words_kept", 32'(ifc.cfg_rdata), 32'(refMem[i]));
    end

    runTransfer("xfer1", 1'b0);
    runTransfer("xfer2_collide", 1'b1);
    runTransfer("xfer3_repeat", 1'b0);

    applyStimulus(1'b0, 0, '0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock);
      #1;
      if (ifc.serial_clock) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midrst_reached_hi", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_sclk",  32'(ifc.serial_clock), 32'd0);
    checkOutput("midrst_busy",  32'(ifc.busy),         32'd0);
    checkOutput("midrst_sload", 32'(ifc.serial_load),  32'd0);
    for (int i = 0; i < NUM_IO; i++) refMem[i] = DEF;
    a = $urandom_range(0, NUM_IO - 1);
    ifc.cfg_addr = 6'(a);
    #1;
    checkOutput("midrst_word_default", 32'(ifc.cfg_rdata), 32'(DEF));
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    runTransfer("xfer4_defaults", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
